// File: rtl/mii_frame_gen_param.sv
// Frame generator: preamble, SFD, patterned payload and EOF packed LANES bytes per
// cycle, followed by a minimum idle gap; bursts of frame_count frames or continuous.
// state   | meaning
// S_IDLE  | idle lanes, waiting for start
// S_FRAME | driving preamble/SFD/payload/EOF words
// S_IPG   | driving the inter-frame idle words
module mii_frame_gen_param #(
    parameter int         LANES         = 1,
    parameter int         PREAMBLE_LEN  = 7,
    parameter int         IDLE_LEN      = 12,
    parameter int         MIN_PAYLOAD   = 46,
    parameter int         MAX_PAYLOAD   = 1500,
    parameter logic [7:0] IDLE_CODE     = 8'h07,
    parameter logic [7:0] PREAMBLE_CODE = 8'h55,
    parameter logic [7:0] SFD_CODE      = 8'hD5,
    parameter logic [7:0] EOF_CODE      = 8'hFD,
    parameter logic [7:0] FILL_CODE     = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [15:0]          payload_len,
    input  logic [15:0]          frame_count,
    input  logic [1:0]           mode,
    output logic [8*LANES-1:0]   tx_data,
    output logic [LANES-1:0]     tx_ctrl,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          frames_sent
);
    localparam int                 IPG_WORDS   = (IDLE_LEN + LANES - 1) / LANES;
    localparam logic [15:0]        C_SFD_POS   = 16'(PREAMBLE_LEN);
    localparam logic [15:0]        C_MIN       = 16'(MIN_PAYLOAD);
    localparam logic [15:0]        C_MAX       = 16'(MAX_PAYLOAD);
    localparam logic [15:0]        C_LANES     = 16'(LANES);
    localparam logic [15:0]        C_IPG_LAST  = 16'(IPG_WORDS - 1);
    localparam logic [8*LANES-1:0] C_IDLE_WORD = {LANES{IDLE_CODE}};

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_IPG} state_t;

    state_t             r_state;
    logic [15:0]        r_idx;
    logic [15:0]        r_len;
    logic [1:0]         r_mode;
    logic [7:0]         r_lfsr;
    logic [15:0]        r_ipg;
    logic [15:0]        r_fc;
    logic [15:0]        r_burst_cnt;
    logic [15:0]        r_frames_sent;
    logic [8*LANES-1:0] r_data;
    logic [LANES-1:0]   r_ctrl;
    logic               r_busy;
    logic               r_frame_done;

    logic [15:0]        w_len_clamped;
    logic [15:0]        w_eof_pos;
    logic               w_exhausted;
    logic [8*LANES-1:0] w_data;
    logic [LANES-1:0]   w_ctrl;
    logic [7:0]         w_lfsr_next;
    logic               w_eof_word;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    assign w_len_clamped = (payload_len < C_MIN) ? C_MIN :
                           (payload_len > C_MAX) ? C_MAX : payload_len;
    assign w_eof_pos     = C_SFD_POS + 16'd1 + r_len;
    assign w_exhausted   = (r_fc != 16'd0) && (r_burst_cnt == r_fc);

    // Each lane decodes its absolute byte position within the frame; lanes past EOF stay idle.
    always_comb begin
        logic [15:0] w_pos;
        logic [7:0]  w_lfsr_run;
        w_data     = C_IDLE_WORD;
        w_ctrl     = '1;
        w_eof_word = 1'b0;
        w_lfsr_run = r_lfsr;
        w_pos      = r_idx;
        for (int i = 0; i < LANES; i++) begin
            w_pos = r_idx + 16'(i);
            if (w_pos < C_SFD_POS) begin
                w_data[8*i +: 8] = PREAMBLE_CODE;
                w_ctrl[i]        = 1'b0;
            end else if (w_pos == C_SFD_POS) begin
                w_data[8*i +: 8] = SFD_CODE;
                w_ctrl[i]        = 1'b0;
            end else if (w_pos < w_eof_pos) begin
                w_ctrl[i] = 1'b0;
                case (r_mode)
                    2'b01:   w_data[8*i +: 8] = 8'(w_pos - C_SFD_POS - 16'd1);
                    2'b10:   w_data[8*i +: 8] = w_lfsr_run;
                    default: w_data[8*i +: 8] = FILL_CODE;
                endcase
                w_lfsr_run = lfsr_step(w_lfsr_run);
            end else if (w_pos == w_eof_pos) begin
                w_data[8*i +: 8] = EOF_CODE;
                w_eof_word       = 1'b1;
            end
        end
        w_lfsr_next = w_lfsr_run;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_len         <= C_MIN;
            r_mode        <= '0;
            r_lfsr        <= 8'hFF;
            r_ipg         <= '0;
            r_fc          <= '0;
            r_burst_cnt   <= '0;
            r_frames_sent <= '0;
            r_data        <= C_IDLE_WORD;
            r_ctrl        <= '1;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_data <= C_IDLE_WORD;
                    r_ctrl <= '1;
                    if (start) begin
                        r_state     <= S_FRAME;
                        r_busy      <= 1'b1;
                        r_fc        <= frame_count;
                        r_burst_cnt <= '0;
                        r_idx       <= '0;
                        r_len       <= w_len_clamped;
                        r_mode      <= mode;
                        r_lfsr      <= 8'hFF;
                    end
                end
                S_FRAME: begin
                    r_data <= w_data;
                    r_ctrl <= w_ctrl;
                    r_idx  <= r_idx + C_LANES;
                    r_lfsr <= w_lfsr_next;
                    if (w_eof_word) begin
                        r_frame_done  <= 1'b1;
                        r_frames_sent <= r_frames_sent + 16'd1;
                        r_burst_cnt   <= r_burst_cnt + 16'd1;
                        r_ipg         <= C_IPG_LAST;
                        r_state       <= S_IPG;
                    end
                end
                S_IPG: begin
                    r_data <= C_IDLE_WORD;
                    r_ctrl <= '1;
                    if (r_ipg == 16'd0) begin
                        if (start && !w_exhausted) begin
                            r_state <= S_FRAME;
                            r_idx   <= '0;
                            r_len   <= w_len_clamped;
                            r_mode  <= mode;
                            r_lfsr  <= 8'hFF;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_ipg <= r_ipg - 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_data     = r_data;
    assign tx_ctrl     = r_ctrl;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign frames_sent = r_frames_sent;

endmodule

// File: doc/mii_frame_gen_param.md
MII_FRAME_GEN_PARAM -- requirements
Module: mii_frame_gen_param

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- LANES, 1, byte lanes per cycle; legal values 1, 2, 4, 8
- PREAMBLE_LEN, 7, preamble bytes per frame
- IDLE_LEN, 12, minimum inter-frame idle bytes
- MIN_PAYLOAD, 46, payload length lower clamp
- MAX_PAYLOAD, 1500, payload length upper clamp
- IDLE_CODE, 8'h07, idle control byte
- PREAMBLE_CODE, 8'h55, preamble byte
- SFD_CODE, 8'hD5, start-of-frame delimiter byte
- EOF_CODE, 8'hFD, end-of-frame control byte
- FILL_CODE, 8'hA5, payload byte in fixed mode

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, single clock; all logic on rising edge
- reset, in, 1, asynchronous, active-high
- start, in, 1, level request to transmit frames
- payload_len, in, 16, payload byte count
- frame_count, in, 16, frames per burst; 0 = continuous
- mode, in, 2, payload pattern: 00 fixed, 01 incrementing, 10 PRBS8, 11 reserved (treated as 00)
- tx_data, out, 8*LANES, byte lanes; lane 0 = bits [7:0] = earliest byte
- tx_ctrl, out, LANES, per lane: 1 = control byte (idle/EOF), 0 = preamble/SFD/payload
- busy, out, 1, high from burst launch until the final IPG word has been sent
- frame_done, out, 1, one-cycle pulse on the cycle the EOF word is driven
- frames_sent, out, 16, frames completed since reset; wraps 0xFFFF -> 0

Function
REQ-003 All outputs SHALL be registered.
REQ-004 FSM states SHALL be S_IDLE, S_FRAME and S_IPG.
REQ-005 In S_IDLE, every lane SHALL carry IDLE_CODE with tx_ctrl=1.
REQ-006 In S_IDLE with start=1 at edge N, the FSM SHALL enter S_FRAME, and the first frame word SHALL appear on tx_data at edge N+1.
REQ-007 Frame byte stream SHALL be: PREAMBLE_LEN x PREAMBLE_CODE, 1 x SFD_CODE, L payload bytes, 1 x EOF_CODE, packed LANES bytes per cycle; every frame starts in lane 0.
REQ-008 L SHALL be payload_len clamped to [MIN_PAYLOAD, MAX_PAYLOAD].
REQ-009 L and mode SHALL be sampled at the launch of each frame and held stable for the whole frame.
REQ-010 frame_count SHALL be sampled only at burst launch from S_IDLE.
REQ-011 Payload byte k (k = 0..L-1) SHALL be:
- fixed mode: FILL_CODE
- incrementing mode: k[7:0]
- PRBS8 mode: LFSR x^8+x^6+x^5+x^4+1, seeded 8'hFF at each frame start, byte 0 = seed, advancing one step per byte (LANES steps per cycle).
REQ-012 Lanes after EOF_CODE in the EOF word SHALL carry IDLE_CODE with tx_ctrl=1; the FSM SHALL then enter S_IPG.
REQ-013 S_IPG SHALL emit ceil(IDLE_LEN/LANES) full idle words; EOF-word fill lanes do not count toward IDLE_LEN.
REQ-014 At S_IPG end, the FSM SHALL launch the next frame only if start=1 and the burst is not exhausted; otherwise it SHALL return to S_IDLE.
REQ-015 A burst SHALL be exhausted after frame_count frames when frame_count != 0, and never while frame_count = 0.
REQ-016 Start deasserted mid-frame SHALL let the current frame and its IPG complete, then stop.
REQ-017 Start reasserted in the last IPG cycle SHALL give back-to-back frames with no extra idle word.
REQ-018 frames_sent SHALL increment on the frame_done cycle.
REQ-019 busy SHALL deassert on the cycle the FSM re-enters S_IDLE.

Reset
REQ-020 While reset=1, the FSM SHALL be in S_IDLE; tx_data = all lanes IDLE_CODE; tx_ctrl = all ones; busy=0; frame_done=0; frames_sent=0; LFSR = 8'hFF.
REQ-021 Reset asserted mid-frame SHALL force the idle outputs asynchronously; no EOF is emitted for the truncated frame.
REQ-022 After reset release, no frame SHALL launch before the first edge with start=1.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- LANES=1, payload_len=46, mode=01, frame_count=1, start pulsed 1 cycle -> 7x55, D5, 00..2D, FD (ctrl=1), 12 x 07; frame_done once; frames_sent=1; busy low after 67 data cycles.
- LANES=8, same stimulus -> 7 frame words; word 6 = bytes 48..54 with EOF in lane 6, lane 7 = 07 (ctrl=1); then 2 idle words; frame period 9 cycles.
- payload_len=10 and payload_len=2000, mode=00 -> payloads of 46 and 1500 x A5 respectively.
- mode=10, LANES=4 -> payload starts FF and follows the LFSR sequence; every frame restarts at FF.
- frame_count=0, start held high for 3 frames then dropped mid-frame 4 -> frame 4 completes with EOF and IPG, then idle; frames_sent=4.
- reset asserted during payload byte 20 -> same cycle, all lanes 07 with ctrl=1; frames_sent=0; the next start produces a clean frame from preamble.
